mod_inv_fermat: RTL
===================

Name: mod_inv_fermat

Overview:
- Computes the modular inverse r = a^(p-2) mod p by Fermat's little theorem, using left-to-right square-and-multiply.
- Sits directly upstream of, and also downstream of, the ModMul multiplier. It issues every square and multiply to an external ModMul instance and consumes each product it returns.
- Used for the affine conversion of MSM results (Z^-1).
- Contains no multiplier of its own; all arithmetic goes through the mul_* port.

Parameters:
- p, 128'd37, prime modulus; must satisfy 3 <= p < 2^width.
- width, 128, operand and result width in bits.
- Local constants:
  - E = p-2, the exponent.
  - MSB = index of the highest set bit of E, computed at elaboration.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  start request, sampled in IDLE only.
- a  in  width  operand; must be < p; sampled in the cycle enable is accepted.
- r  out  width  result; held stable from the done cycle until the next accepted start.
- done  out  1  one-cycle pulse when r is valid.
- err  out  1  set with done when a == 0 (no inverse exists); cleared on the next start.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- mul_a  out  width  multiplier operand A.
- mul_b  out  width  multiplier operand B.
- mul_enable  out  1  one-cycle request pulse to the multiplier.
- mul_r  in  width  multiplier product.
- mul_done  in  1  one-cycle pulse marking mul_r valid.

Behaviour:
- Reset (async, reset=0) forces:
  - state = IDLE;
  - r, mul_a and mul_b = 0;
  - done, err, busy and mul_enable = 0.
- Reset asserted mid-operation aborts the computation. After reset releases, any in-flight mul_done is ignored.
- Registers:
  - base: latched copy of a.
  - acc: running result, width bits.
  - idx: bit index into E, signed, wide enough to hold -1.
- FSM states: IDLE, LOAD, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FINISH.
- IDLE: if enable=1, latch base=a, clear err, go to LOAD. busy rises the next cycle.
- LOAD:
  - If base==0: acc=0, err=1, go to FINISH.
  - Else: acc=base, idx=MSB-1.
  - If idx<0, go to FINISH; otherwise go to SQR_REQ.
- SQR_REQ: drive mul_a=mul_b=acc and mul_enable=1 for this one cycle, then go to SQR_WAIT.
- SQR_WAIT: on mul_done, set acc=mul_r.
  - If E[idx]=1, go to MUL_REQ.
  - Else decrement idx, then go to FINISH if idx becomes <0, otherwise to SQR_REQ.
- MUL_REQ: drive mul_a=acc, mul_b=base, mul_enable=1 for one cycle, then go to MUL_WAIT.
- MUL_WAIT: on mul_done, set acc=mul_r, decrement idx, then go to FINISH if idx<0, otherwise to SQR_REQ.
- FINISH: r=acc and done=1 for exactly one cycle, then return to IDLE. busy drops the cycle after done.
- Multiplier handshake:
  - mul_a and mul_b are held stable from the request cycle until mul_done is sampled.
  - Never more than one request is outstanding.
  - mul_done is ignored in every state other than SQR_WAIT and MUL_WAIT.
  - Multiplier latency is arbitrary, with at least 1 cycle between request and mul_done.
- enable while busy is ignored; it is not queued.
- enable held high across FINISH starts a new operation on the first IDLE cycle.
- Operation count: (MSB) squares plus (popcount(E)-1) multiplies.
  - p=37, E=35=100011b: 5 squares + 2 multiplies = 7 requests.
  - p=3, E=1: 0 requests; done asserts 2 cycles after the enable-accept cycle.
- Latency: done asserts 1 cycle after the final mul_done is sampled. When no multiplier requests are issued (p=3, or a==0), done asserts 2 cycles after the start is accepted.
- Arithmetic: the block only moves values; all reduction is done by the multiplier. Behaviour with a >= p is undefined.

Test Plan:
- Bench setup: behavioural mod-p multiplier model with configurable latency L; parameters p=37, width=128 unless stated.
- p=37, a=5, L=3 -> exactly 7 mul_enable pulses; done pulse with r=15, err=0; busy low after done.
- p=37, a=1 -> r=1. Then a=36 -> r=36. Then a=0 -> r=0, err=1, zero mul_enable pulses, done 2 cycles after start.
- p=3, a=2 -> r=2, zero mul_enable pulses, done 2 cycles after the accept cycle.
- p=37, a=5, L randomized 1..10 per request, plus spurious mul_done pulses while in IDLE and in SQR_REQ -> r=15; mul_a and mul_b never change while a request is outstanding.
- Apply reset=0 during the 4th request's wait, release, then start a=6 -> outputs zero during reset; the stale mul_done is ignored; r=31 (6*31=186=5*37+1).
- Pulse enable during busy with a=2 -> ignored; the original result (a=5 -> 15) is returned, followed by a single done pulse.

Source files
------------

// File: rtl/mod_inv_fermat.sv
// Modular inverse r = a^(p-2) mod p using left-to-right square-and-multiply.
// The block has no multiplier; every square and multiply goes out on the mul_* port.
//
// state    | meaning
// IDLE     | waiting for enable
// LOAD     | seed acc with base, choose the first exponent bit
// SQR_REQ  | square request on the port (mul_enable high)
// SQR_WAIT | waiting for the square product
// MUL_REQ  | multiply-by-base request on the port (mul_enable high)
// MUL_WAIT | waiting for the multiply product
// FINISH   | done pulse, r valid
module mod_inv_fermat #(
    parameter int               width = 128,
    parameter logic [width-1:0] p     = 128'd37
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [width-1:0] a,
    output logic [width-1:0] r,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [width-1:0] mul_a,
    output logic [width-1:0] mul_b,
    output logic             mul_enable,
    input  logic [width-1:0] mul_r,
    input  logic             mul_done
);

    localparam logic [width-1:0] e  = p - width'(2);
    localparam int               iw = $clog2(width) + 1;

    function automatic int msb_of(input logic [width-1:0] v);
        int m = 0;
        for (int i = 0; i < width; i++) begin
            if (v[i]) m = i;
        end
        return m;
    endfunction

    localparam int                   msb       = msb_of(e);
    localparam logic signed [iw-1:0] idx_start = iw'(msb - 1);
    localparam logic signed [iw-1:0] idx_one   = iw'(1);

    typedef enum logic [2:0] {
        IDLE, LOAD, SQR_REQ, SQR_WAIT, MUL_REQ, MUL_WAIT, FINISH
    } state_t;

    state_t                  state;
    logic [width-1:0]        base;
    logic [width-1:0]        acc;
    logic signed [iw-1:0]    idx;
    logic                    mul_sel;
    logic                    e_bit;

    // acc doubles as operand A; operand B is acc for squares, base for multiplies.
    assign mul_a = acc;
    assign mul_b = mul_sel ? base : acc;
    assign e_bit = e[idx[iw-2:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            base       <= '0;
            acc        <= '0;
            idx        <= '0;
            mul_sel    <= 1'b0;
            r          <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            mul_enable <= 1'b0;
        end else begin
            mul_enable <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        base  <= a;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (base == '0) begin
                        acc   <= '0;
                        err   <= 1'b1;
                        r     <= '0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        acc     <= base;
                        idx     <= idx_start;
                        mul_sel <= 1'b0;
                        if (idx_start < 0) begin
                            r     <= base;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            mul_enable <= 1'b1;
                            state      <= SQR_REQ;
                        end
                    end
                end
                SQR_REQ: state <= SQR_WAIT;
                SQR_WAIT: begin
                    if (mul_done) begin
                        acc <= mul_r;
                        if (e_bit) begin
                            mul_sel    <= 1'b1;
                            mul_enable <= 1'b1;
                            state      <= MUL_REQ;
                        end else if (idx == '0) begin
                            r     <= mul_r;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx        <= idx - idx_one;
                            mul_sel    <= 1'b0;
                            mul_enable <= 1'b1;
                            state      <= SQR_REQ;
                        end
                    end
                end
                MUL_REQ: state <= MUL_WAIT;
                MUL_WAIT: begin
                    if (mul_done) begin
                        acc <= mul_r;
                        if (idx == '0) begin
                            r     <= mul_r;
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            idx        <= idx - idx_one;
                            mul_sel    <= 1'b0;
                            mul_enable <= 1'b1;
                            state      <= SQR_REQ;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
